mips32_load_writeback: RTL and testbench

- Writeback stage of the MIPS32_1 pipeline. Sits directly upstream of the general purpose register file and drives its write port A: address, data, valid and the per-byte write enables (LoadByte).
- Retires ALU results in one cycle.
- For loads, waits for the data-memory read response, then aligns, sign/zero-extends or merges (LWL/LWR) the data.
- Holds the pipeline with a stall while a load is outstanding, and times out lost memory responses.

---
 rtl/mips32_load_writeback.sv | 173 +++++++++++++++++
 tb/tb_mips32_load_writeback.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_load_writeback.sv
// rtl/mips32_load_writeback.sv - MIPS32 writeback stage: ALU retire, load align/extend/merge, stall and timeout
module mips32_load_writeback #(
   parameter int N       = 32,
   parameter int O       = 5,
   parameter int TIMEOUT = 255,
   parameter int TW      = $clog2(TIMEOUT + 1)
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         wb_val,
   output logic         wb_rdy,
   input  logic [O-1:0] wb_adr,
   input  logic [N-1:0] wb_res,
   input  logic         wb_is_load,
   input  logic [2:0]   wb_ltype,
   input  logic         mem_rvalid,
   input  logic [N-1:0] mem_rdata,
   output logic [O-1:0] gpr_wr_adr,
   output logic [N-1:0] gpr_wr_dat,
   output logic         gpr_wr_val,
   output logic [3:0]   gpr_byte_en,
   output logic         stall,
   output logic         addr_err,
   output logic         bus_err
);

   localparam logic [2:0] LT_LB  = 3'd0;
   localparam logic [2:0] LT_LBU = 3'd1;
   localparam logic [2:0] LT_LH  = 3'd2;
   localparam logic [2:0] LT_LHU = 3'd3;
   localparam logic [2:0] LT_LW  = 3'd4;
   localparam logic [2:0] LT_LWL = 3'd5;
   localparam logic [2:0] LT_LWR = 3'd6;
   localparam logic [2:0] LT_RSV = 3'd7;

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_MEM = 1'b1
   } state_t;

   state_t        state_q;
   logic [O-1:0]  ld_adr_q;
   logic [2:0]    ld_type_q;
   logic [1:0]    ld_k_q;
   logic [TW-1:0] cnt_q;

   logic [O-1:0]  wr_adr_q;
   logic [N-1:0]  wr_dat_q;
   logic          wr_val_q;
   logic [3:0]    wr_be_q;
   logic          addr_err_q;
   logic          bus_err_q;

   logic          misalign;
   logic [N-1:0]  lane_w;
   logic [N-1:0]  fmt_dat_d;
   logic [3:0]    fmt_be_d;

   // Handshake and hold are pure decodes of the state register
   assign wb_rdy      = (state_q == IDLE);
   assign stall       = (state_q == WAIT_MEM);
   assign gpr_wr_adr  = wr_adr_q;
   assign gpr_wr_dat  = wr_dat_q;
   assign gpr_wr_val  = wr_val_q;
   assign gpr_byte_en = wr_be_q;
   assign addr_err    = addr_err_q;
   assign bus_err     = bus_err_q;

   // Alignment check on the incoming request; unaligned halfwords/words and the reserved type abort at accept
   always_comb begin
      misalign = 1'b0;
      case (wb_ltype)
         LT_LH, LT_LHU: misalign = wb_res[0];
         LT_LW:         misalign = (wb_res[1:0] != 2'b00);
         LT_RSV:        misalign = 1'b1;
         default:       misalign = 1'b0;
      endcase
   end

   // Format the returned word: lane select and extend, or LWL/LWR shift with partial byte enables
   always_comb begin
      lane_w    = mem_rdata >> {ld_k_q, 3'b000};
      fmt_dat_d = mem_rdata;
      fmt_be_d  = 4'hF;
      case (ld_type_q)
         LT_LB:  fmt_dat_d = {{(N-8){lane_w[7]}}, lane_w[7:0]};
         LT_LBU: fmt_dat_d = {{(N-8){1'b0}}, lane_w[7:0]};
         LT_LH:  fmt_dat_d = {{(N-16){lane_w[15]}}, lane_w[15:0]};
         LT_LHU: fmt_dat_d = {{(N-16){1'b0}}, lane_w[15:0]};
         LT_LWR: begin
            fmt_dat_d = lane_w;
            fmt_be_d  = 4'hF >> ld_k_q;
         end
         LT_LWL: begin
            // ~k equals 3-k for a 2-bit offset
            fmt_dat_d = mem_rdata << {~ld_k_q, 3'b000};
            fmt_be_d  = 4'hF << (~ld_k_q);
         end
         default: begin
            fmt_dat_d = mem_rdata;
            fmt_be_d  = 4'hF;
         end
      endcase
   end

   // Writeback FSM: retires ALU results, tracks one outstanding load, and registers every output pulse
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         ld_adr_q   <= '0;
         ld_type_q  <= '0;
         ld_k_q     <= '0;
         cnt_q      <= '0;
         wr_adr_q   <= '0;
         wr_dat_q   <= '0;
         wr_val_q   <= 1'b0;
         wr_be_q    <= '0;
         addr_err_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         wr_val_q   <= 1'b0;
         addr_err_q <= 1'b0;
         bus_err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               // A response with nothing outstanding is a protocol error, never written back
               if (mem_rvalid) begin
                  bus_err_q <= 1'b1;
               end
               if (wb_val) begin
                  if (!wb_is_load) begin
                     // r0 writes are suppressed and the write port keeps its previous contents
                     if (wb_adr != '0) begin
                        wr_val_q <= 1'b1;
                        wr_adr_q <= wb_adr;
                        wr_dat_q <= wb_res;
                        wr_be_q  <= 4'hF;
                     end
                  end else if (misalign) begin
                     addr_err_q <= 1'b1;
                  end else begin
                     ld_adr_q  <= wb_adr;
                     ld_type_q <= wb_ltype;
                     ld_k_q    <= wb_res[1:0];
                     cnt_q     <= '0;
                     state_q   <= WAIT_MEM;
                  end
               end
            end
            WAIT_MEM: begin
               // Data arriving in the expiry cycle takes priority over the timeout
               if (mem_rvalid) begin
                  if (ld_adr_q != '0) begin
                     wr_val_q <= 1'b1;
                     wr_adr_q <= ld_adr_q;
                     wr_dat_q <= fmt_dat_d;
                     wr_be_q  <= fmt_be_d;
                  end
                  state_q <= IDLE;
               end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                  bus_err_q <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips32_load_writeback.sv
// tb/tb_mips32_load_writeback.sv - self-checking bench for mips32_load_writeback
module tb_mips32_load_writeback;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        wb_val = 1'b0;
   logic        wb_rdy;
   logic [4:0]  wb_adr = '0;
   logic [31:0] wb_res = '0;
   logic        wb_is_load = 1'b0;
   logic [2:0]  wb_ltype = '0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [4:0]  gpr_wr_adr;
   logic [31:0] gpr_wr_dat;
   logic        gpr_wr_val;
   logic [3:0]  gpr_byte_en;
   logic        stall;
   logic        addr_err;
   logic        bus_err;

   mips32_load_writeback #(.N(32), .O(5), .TIMEOUT(4)) dut (
      .clk(clk), .rstn(rstn),
      .wb_val(wb_val), .wb_rdy(wb_rdy), .wb_adr(wb_adr), .wb_res(wb_res),
      .wb_is_load(wb_is_load), .wb_ltype(wb_ltype),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .gpr_wr_adr(gpr_wr_adr), .gpr_wr_dat(gpr_wr_dat), .gpr_wr_val(gpr_wr_val),
      .gpr_byte_en(gpr_byte_en), .stall(stall), .addr_err(addr_err), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ld;
      logic [2:0]  lt;
      logic [4:0]  adr;
      logic [31:0] res;
      logic [31:0] rdata;
      int          lat;
      logic        aerr;
      logic [31:0] dat;
      logic [3:0]  be;
   } vec_t;

   typedef struct {
      logic [4:0]  adr;
      logic [31:0] dat;
      logic [3:0]  be;
   } wr_t;

   vec_t vecs[$];
   wr_t  exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   n_wr_exp = 0;
   int   n_wr_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic ld, input logic [2:0] lt, input logic [4:0] adr,
                               input logic [31:0] res, input logic [31:0] rdata, input int lat,
                               input logic aerr, input logic [31:0] dat, input logic [3:0] be);
      vec_t v;
      v.ld = ld; v.lt = lt; v.adr = adr; v.res = res; v.rdata = rdata;
      v.lat = lat; v.aerr = aerr; v.dat = dat; v.be = be;
      return v;
   endfunction

   function automatic wr_t mkw(input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] be);
      wr_t w;
      w.adr = adr; w.dat = dat; w.be = be;
      return w;
   endfunction

   // Scoreboard: every write port pulse must match the oldest expected write
   always @(negedge clk) begin
      if (rstn && gpr_wr_val) begin
         n_wr_seen++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: adr=%0d dat=%h be=%h expected none at %0t",
                     gpr_wr_adr, gpr_wr_dat, gpr_byte_en, $time);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_adr", 32'(gpr_wr_adr), 32'(e.adr));
            chk("wr_dat", gpr_wr_dat, e.dat);
            chk("wr_be", 32'(gpr_byte_en), 32'(e.be));
         end
      end
   end

   task automatic send(input logic ld, input logic [2:0] lt, input logic [4:0] adr, input logic [31:0] res);
      wb_val = 1'b1; wb_is_load = ld; wb_ltype = lt; wb_adr = adr; wb_res = res;
      if (!ld && adr != 5'd0) begin
         exp_q.push_back(mkw(adr, res, 4'hF));
         n_wr_exp++;
      end
      @(posedge clk); #1;
      wb_val = 1'b0; wb_is_load = 1'b0;
   endtask

   initial begin
      int ns;
      int guard;
      // LDR types: 0=LB 1=LBU 2=LH 3=LHU 4=LW 5=LWL 6=LWR 7=reserved
      vecs.push_back(mk(0, 3'd0, 5'd3,  32'hDEADBEEF, 32'h0,         0, 0, 32'hDEADBEEF, 4'hF));
      vecs.push_back(mk(0, 3'd0, 5'd0,  32'h11111111, 32'h0,         0, 0, 32'h0,        4'h0));
      vecs.push_back(mk(1, 3'd0, 5'd5,  32'h00001002, 32'h12803456,  3, 0, 32'hFFFFFF80, 4'hF));
      vecs.push_back(mk(1, 3'd1, 5'd5,  32'h00001002, 32'h12803456,  1, 0, 32'h00000080, 4'hF));
      vecs.push_back(mk(1, 3'd0, 5'd8,  32'h00000000, 32'h1280347F,  2, 0, 32'h0000007F, 4'hF));
      vecs.push_back(mk(1, 3'd2, 5'd6,  32'h00000002, 32'h87654321,  1, 0, 32'hFFFF8765, 4'hF));
      vecs.push_back(mk(1, 3'd3, 5'd6,  32'h00000000, 32'h87654321,  2, 0, 32'h00004321, 4'hF));
      vecs.push_back(mk(1, 3'd4, 5'd7,  32'h00000100, 32'hCAFEF00D,  1, 0, 32'hCAFEF00D, 4'hF));
      vecs.push_back(mk(1, 3'd5, 5'd9,  32'h00000001, 32'hAABBCCDD,  1, 0, 32'hCCDD0000, 4'hC));
      vecs.push_back(mk(1, 3'd5, 5'd9,  32'h00000002, 32'hAABBCCDD,  2, 0, 32'hBBCCDD00, 4'hE));
      vecs.push_back(mk(1, 3'd5, 5'd9,  32'h00000003, 32'hAABBCCDD,  1, 0, 32'hAABBCCDD, 4'hF));
      vecs.push_back(mk(1, 3'd6, 5'd10, 32'h00000001, 32'hAABBCCDD,  1, 0, 32'h00AABBCC, 4'h7));
      vecs.push_back(mk(1, 3'd6, 5'd10, 32'h00000003, 32'hAABBCCDD,  1, 0, 32'h000000AA, 4'h1));
      vecs.push_back(mk(1, 3'd2, 5'd11, 32'h00000001, 32'h0,         0, 1, 32'h0,        4'h0));
      vecs.push_back(mk(1, 3'd4, 5'd11, 32'h00000002, 32'h0,         0, 1, 32'h0,        4'h0));
      vecs.push_back(mk(1, 3'd7, 5'd11, 32'h00000000, 32'h0,         0, 1, 32'h0,        4'h0));
      vecs.push_back(mk(1, 3'd0, 5'd0,  32'h00000000, 32'h000000FF,  2, 0, 32'h0,        4'h0));
      vecs.push_back(mk(1, 3'd4, 5'd12, 32'h00000000, 32'h13572468,  4, 0, 32'h13572468, 4'hF));

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_wb_rdy", 32'(wb_rdy), 32'd1);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_wr_val", 32'(gpr_wr_val), 32'd0);
      chk("rst_wr_dat", gpr_wr_dat, 32'd0);
      chk("rst_errs", {30'd0, addr_err, bus_err}, 32'd0);
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;

      // Table-driven requests
      foreach (vecs[i]) begin
         vec_t v;
         v = vecs[i];
         send(v.ld, v.lt, v.adr, v.res);
         if (v.aerr) begin
            @(negedge clk);
            chk("addr_err_pulse", 32'(addr_err), 32'd1);
            chk("addr_err_stall", 32'(stall), 32'd0);
            chk("addr_err_rdy", 32'(wb_rdy), 32'd1);
            @(posedge clk); #1;
         end else if (v.ld) begin
            ns = 0;
            for (int c = 0; c < v.lat; c++) begin
               if (c == v.lat - 1) begin
                  mem_rvalid = 1'b1;
                  mem_rdata  = v.rdata;
                  if (v.adr != 5'd0) begin
                     exp_q.push_back(mkw(v.adr, v.dat, v.be));
                     n_wr_exp++;
                  end
               end
               @(negedge clk);
               if (stall) ns++;
               @(posedge clk); #1;
               mem_rvalid = 1'b0;
            end
            chk("load_stall_cycles", 32'(ns), 32'(v.lat));
            @(negedge clk);
            chk("load_done_stall", 32'(stall), 32'd0);
            chk("load_done_rdy", 32'(wb_rdy), 32'd1);
            chk("load_no_bus_err", 32'(bus_err), 32'd0);
            @(posedge clk); #1;
         end else begin
            @(negedge clk);
            chk("alu_rdy", 32'(wb_rdy), 32'd1);
            @(posedge clk); #1;
         end
      end

      // Back-to-back ALU results, one write per cycle
      for (int j = 0; j < 3; j++) begin
         wb_val = 1'b1; wb_is_load = 1'b0; wb_adr = 5'(20 + j); wb_res = 32'hA5A50000 + 32'(j);
         exp_q.push_back(mkw(5'(20 + j), 32'hA5A50000 + 32'(j), 4'hF));
         n_wr_exp++;
         @(negedge clk);
         chk("b2b_rdy", 32'(wb_rdy), 32'd1);
         @(posedge clk); #1;
      end
      wb_val = 1'b0;
      @(negedge clk);
      chk("b2b_last_val", 32'(gpr_wr_val), 32'd1);
      @(posedge clk); #1;

      // Lost response: timeout after TIMEOUT stall cycles
      send(1'b1, 3'd4, 5'd13, 32'h0);
      ns = 0;
      guard = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (!stall) break;
         ns++;
         guard++;
      end
      chk("timeout_stall_cycles", 32'(ns), 32'd4);
      chk("timeout_bus_err", 32'(bus_err), 32'd1);
      chk("timeout_rdy", 32'(wb_rdy), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("timeout_bus_err_pulse", 32'(bus_err), 32'd0);
      @(posedge clk); #1;

      // Stray response while idle
      mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      @(negedge clk);
      chk("stray_bus_err", 32'(bus_err), 32'd1);
      chk("stray_no_write", 32'(gpr_wr_val), 32'd0);
      @(posedge clk); #1;

      // Reset while a load is outstanding drops it
      send(1'b1, 3'd4, 5'd14, 32'h0);
      @(negedge clk);
      chk("pre_reset_stall", 32'(stall), 32'd1);
      @(posedge clk); #1;
      rstn = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      @(negedge clk);
      chk("post_reset_no_write", 32'(gpr_wr_val), 32'd0);
      chk("post_reset_stall", 32'(stall), 32'd0);
      chk("post_reset_rdy", 32'(wb_rdy), 32'd1);
      repeat (2) @(posedge clk);
      #1;

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      chk("write_count", 32'(n_wr_seen), 32'(n_wr_exp));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
